// File: rtl/io_harness_pkg.sv
// Shared state encoding and defaults for the io_harness stimulus/capture block.
package io_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_DUT,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam int IO_HARNESS_RST_CYCLES = 4;

endpackage

// File: rtl/io_harness_mem.sv
// DEPTH x W RAM: synchronous write, registered read with a clearable output register.
module io_harness_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/io_harness.sv
// Replays a pattern into a DUT and captures its outputs, optionally after a masked trigger.
// Build option: define IO_HARNESS_TRIGGER_EN to enable the ARM/trigger stage.
module io_harness
  import io_harness_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int DEPTH      = 16,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = IO_HARNESS_RST_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pat_we,
  input  logic [$clog2(DEPTH)-1:0] pat_addr,
  input  logic [IN_W-1:0]          pat_data,
  input  logic [$clog2(DEPTH):0]   pat_len,
  input  logic [DIV_W-1:0]         step_div,
  input  logic [OUT_W-1:0]         trig_mask,
  input  logic [OUT_W-1:0]         trig_value,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     rd_en,
  output logic [IN_W-1:0]          dut_ui,
  input  logic [OUT_W-1:0]         dut_uo,
  output logic                     dut_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     triggered,
  output logic [OUT_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   cap_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_q, div_d;
  logic [CW-1:0]    len_q, len_d, cap_count_q, cap_count_d;
  logic [AW-1:0]    idx_q, idx_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             triggered_q, triggered_d, rd_valid_q;
  logic [OUT_W-1:0] dut_uo_q;
  logic [IN_W-1:0]  pat_rdata;
  logic             active, idle_like, step, start_ok, pop_ok, cap_we, pat_wr;

`ifdef IO_HARNESS_TRIGGER_EN
  logic [OUT_W-1:0] mask_q, mask_d, value_q, value_d;
  logic             trig_hit;
  assign trig_hit = ((dut_uo_q ^ value_q) & mask_q) == '0;
  assign cap_we   = !abort && step &&
                    ((state_q == ST_CAPTURE) || ((state_q == ST_ARM) && trig_hit));
`else
  logic unused_trig;
  assign unused_trig = ^{trig_mask, trig_value};
  assign cap_we      = !abort && step && (state_q == ST_CAPTURE);
`endif

  assign active    = (state_q == ST_RESET_DUT) || (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign step      = ((state_q == ST_ARM) || (state_q == ST_CAPTURE)) && (div_cnt_q == div_q);
  assign start_ok  = start && idle_like && !abort;
  assign pop_ok    = rd_en && (state_q == ST_DONE) && (cap_count_q != '0) && !abort && !start_ok;
  assign pat_wr    = pat_we && idle_like;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    div_cnt_d   = div_cnt_q;
    div_d       = div_q;
    len_d       = len_q;
    cap_count_d = cap_count_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    triggered_d = triggered_q;
`ifdef IO_HARNESS_TRIGGER_EN
    mask_d      = mask_q;
    value_d     = value_q;
`endif
    if (abort) begin
      state_d     = ST_IDLE;
      cap_count_d = '0;
      idx_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            cap_count_d = cap_count_q - 1'b1;
          end
          if (start_ok) begin
            state_d     = ST_RESET_DUT;
            rst_cnt_d   = '0;
            idx_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cap_count_d = '0;
            triggered_d = 1'b0;
            div_d       = step_div;
            // A length of 0 or anything beyond the memory means "whole memory".
            len_d       = ((pat_len == '0) || (pat_len > CW'(DEPTH))) ? CW'(DEPTH) : pat_len;
`ifdef IO_HARNESS_TRIGGER_EN
            mask_d      = trig_mask;
            value_d     = trig_value;
`endif
          end
        end
        ST_RESET_DUT: begin
          if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
            div_cnt_d = '0;
`ifdef IO_HARNESS_TRIGGER_EN
            state_d   = ST_ARM;
`else
            state_d   = ST_CAPTURE;
`endif
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ST_ARM, ST_CAPTURE: begin
          if (step) begin
            div_cnt_d = '0;
            idx_d     = ({1'b0, idx_q} == (len_q - 1'b1)) ? '0 : idx_q + 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
          if (cap_we) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            cap_count_d = cap_count_q + 1'b1;
            triggered_d = 1'b1;
            state_d     = (cap_count_q == CW'(DEPTH - 1)) ? ST_DONE : ST_CAPTURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      div_cnt_q   <= '0;
      div_q       <= '0;
      len_q       <= '0;
      cap_count_q <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      dut_uo_q    <= '0;
`ifdef IO_HARNESS_TRIGGER_EN
      mask_q      <= '0;
      value_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      div_cnt_q   <= div_cnt_d;
      div_q       <= div_d;
      len_q       <= len_d;
      cap_count_q <= cap_count_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= pop_ok;
      dut_uo_q    <= dut_uo;
`ifdef IO_HARNESS_TRIGGER_EN
      mask_q      <= mask_d;
      value_q     <= value_d;
`endif
    end
  end

  // Reading at the next index keeps the registered RAM output aligned with idx_q.
  io_harness_mem #(.DEPTH(DEPTH), .W(IN_W)) u_pat_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (pat_wr),
    .waddr (pat_addr),
    .wdata (pat_data),
    .re    (1'b1),
    .raddr (idx_d),
    .rdata (pat_rdata)
  );

  io_harness_mem #(.DEPTH(DEPTH), .W(OUT_W)) u_cap_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_we),
    .waddr (wr_ptr_q),
    .wdata (dut_uo_q),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign dut_ui    = active ? pat_rdata : '0;
  assign dut_rst_n = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign busy      = active;
  assign done      = (state_q == ST_DONE);
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign cap_count = cap_count_q;

endmodule

// File: tb/tb_io_harness.sv
// Directed bench for io_harness with dut_ui looped back to dut_uo and a capture scoreboard.
module tb_io_harness;
  localparam int IN_W = 8, OUT_W = 8, DEPTH = 16, DIV_W = 8, AW = 4, CW = 5;

  logic clk = 1'b0, rst = 1'b1, pat_we = 1'b0, start = 1'b0, abort = 1'b0, rd_en = 1'b0;
  logic [AW-1:0]    pat_addr = '0;
  logic [IN_W-1:0]  pat_data = '0;
  logic [CW-1:0]    pat_len = '0;
  logic [DIV_W-1:0] step_div = '0;
  logic [OUT_W-1:0] trig_mask = '0, trig_value = '0;
  logic [IN_W-1:0]  dut_ui;
  logic [OUT_W-1:0] dut_uo, rd_data;
  logic             dut_rst_n, busy, done, triggered, rd_valid;
  logic [CW-1:0]    cap_count;

  int n_checks = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ui_seq[$];
  int         chg_c[$];
  int         rise_c, high_cnt, done_c;
  logic [7:0] pattern [3] = '{8'h01, 8'h02, 8'h03};

  always #5 clk = ~clk;
  assign dut_uo = dut_ui;

  io_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .pat_len(pat_len), .step_div(step_div), .trig_mask(trig_mask), .trig_value(trig_value),
    .start(start), .abort(abort), .rd_en(rd_en), .dut_ui(dut_ui), .dut_uo(dut_uo),
    .dut_rst_n(dut_rst_n), .busy(busy), .done(done), .triggered(triggered),
    .rd_data(rd_data), .rd_valid(rd_valid), .cap_count(cap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a run and watch it until done (bounded), recording reset/step timing and dut_ui.
  task automatic run_watch(input logic [7:0] div, input logic [7:0] mask, input logic [7:0] value,
                           input bit poke_pat);
    logic [7:0] prev_ui;
    prev_ui = '0;
    rise_c = -1; high_cnt = 0; done_c = -1;
    ui_seq.delete(); chg_c.delete();
    step_div = div; trig_mask = mask; trig_value = value; pat_len = 5'd3;
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_pat && c >= 2 && c <= 8) begin
        pat_we = 1'b1; pat_addr = 4'd1; pat_data = 8'hEE;
      end else begin
        pat_we = 1'b0;
      end
      if (dut_rst_n && rise_c < 0) rise_c = c;
      if (busy && (ui_seq.size() == 0 || dut_ui != prev_ui)) begin
        ui_seq.push_back(dut_ui);
        chg_c.push_back(c);
      end
      prev_ui = dut_ui;
      if (dut_rst_n) high_cnt++;
      if (done) begin
        done_c = c;
        break;
      end
    end
    pat_we = 1'b0;
    $display("run div=%0d mask=%02h value=%02h: rst_low=%0d high=%0d done_at=%0d", div, mask, value,
             rise_c, high_cnt, done_c);
    check("run_reaches_done", (done_c >= 0), 1);
    check("done_cap_count", cap_count, 16);
    check("done_triggered", triggered, 1);
  endtask

  // 17 back-to-back pops; every rd_valid is compared against the scoreboard head.
  task automatic readout(input string tag);
    int got;
    got = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) rd_en = 1'b0;
      if (rd_valid) begin
        $display("%s rd %0d: data=0x%02h", tag, got, rd_data);
        if (exp_q.size() > 0) check({tag, "_data"}, rd_data, exp_q.pop_front());
        else check({tag, "_extra_valid"}, 1, 0);
        got++;
      end
    end
    check({tag, "_valid_count"}, got, 16);
    check({tag, "_cap_count_end"}, cap_count, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int bad;
    int wait_ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_dut_ui", dut_ui, 0);
    check("rst_cap_count", cap_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_triggered", triggered, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut_rst_n !== 1'b0 || dut_ui !== 8'h00 || busy !== 1'b0 || cap_count !== '0) bad++;
    end
    check("idle_20_cycles", bad, 0);

    for (int i = 0; i < 3; i++) begin
      pat_we = 1'b1; pat_addr = AW'(i); pat_data = pattern[i];
      @(negedge clk);
    end
    pat_we = 1'b0;

    // Run 1: mask 0 fires on the first step, which samples the value held during reset.
    for (int k = 0; k < 16; k++) exp_q.push_back((k == 0) ? pattern[0] : pattern[(k - 1) % 3]);
    run_watch(8'd0, 8'h00, 8'h00, 1'b0);
    check("r1_rst_low_cycles", rise_c, 4);
    check("r1_high_cycles", high_cnt, 16);
    check("r1_first_step", chg_c.size() > 1 ? chg_c[1] - rise_c : -1, 1);
    check("r1_ui_len", ui_seq.size(), 16);
    for (int k = 0; k < 6; k++) check("r1_ui_seq", ui_seq.size() > k ? ui_seq[k] : 8'hXX, pattern[k % 3]);
    readout("r1");

    // Run 2: loopback trigger on 0x03.
`ifdef IO_HARNESS_TRIGGER_EN
    for (int k = 0; k < 16; k++) exp_q.push_back(pattern[(k + 2) % 3]);
`else
    for (int k = 0; k < 16; k++) exp_q.push_back((k == 0) ? pattern[0] : pattern[(k - 1) % 3]);
`endif
    run_watch(8'd0, 8'hFF, 8'h03, 1'b0);
    readout("r2");

    // Run 3: step_div = 3, one step every 4 cycles.
    for (int k = 0; k < 16; k++) exp_q.push_back(pattern[k % 3]);
    run_watch(8'd3, 8'h00, 8'h00, 1'b0);
    check("r3_first_step", chg_c.size() > 1 ? chg_c[1] - rise_c : -1, 4);
    bad = 0;
    for (int k = 2; k < chg_c.size(); k++) if (chg_c[k] - chg_c[k - 1] != 4) bad++;
    check("r3_step_interval", bad, 0);
    check("r3_ui_len", ui_seq.size(), 16);
    check("r3_high_cycles", high_cnt, 64);
    readout("r3");

    // Run 4: pattern writes while busy must be dropped.
    for (int k = 0; k < 16; k++) exp_q.push_back((k == 0) ? pattern[0] : pattern[(k - 1) % 3]);
    run_watch(8'd0, 8'h00, 8'h00, 1'b1);
    readout("r4");

    // Abort mid-capture.
    step_div = 8'd3; trig_mask = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (dut_rst_n) begin
        wait_ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_run", wait_ok, 1);
    repeat (12) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    check("abort_pre_cap_count", cap_count, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort: busy=%0d done=%0d dut_rst_n=%0d cap_count=%0d", busy, done, dut_rst_n, cap_count);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dut_rst_n", dut_rst_n, 0);
    check("abort_cap_count", cap_count, 0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("abort_rd_ignored", rd_valid, 0);

    // start together with abort stays idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    $display("start+abort: busy=%0d dut_rst_n=%0d", busy, dut_rst_n);
    check("start_abort_busy", busy, 0);
    check("start_abort_dut_rst_n", dut_rst_n, 0);
    repeat (2) @(negedge clk);
    check("start_abort_still_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/io_harness.md
# io_harness

On-FPGA stimulus/capture harness wrapped around a TinyQV-style core in the generic FPGA build. It holds the core in reset, then replays a loaded pattern on the core's dedicated inputs at a programmable rate. It records the core's dedicated outputs into a capture buffer, optionally starting on a masked trigger match. Host logic reads the buffer back after completion. It generalises the fixed 8-in/8-out bench wiring to parametrised widths and depth, and adds sequencing, triggering and buffering.

## Interface
Parameters:
- IN_W, 8, width of the DUT dedicated-input bus
- OUT_W, 8, width of the DUT dedicated-output bus
- DEPTH, 16, pattern and capture entries; power of two, at least 2
- DIV_W, 8, width of the step divider
- RST_CYCLES, 4, cycles the DUT reset is held after start

Ports:
- clk  in  1  single clock for the block and the DUT
- rst  in  1  synchronous, active-high reset
- pat_we  in  1  pattern-memory write strobe
- pat_addr  in  $clog2(DEPTH)  pattern write address
- pat_data  in  IN_W  pattern word
- pat_len  in  $clog2(DEPTH)+1  pattern length; 0 is treated as DEPTH; values above DEPTH are clamped to DEPTH
- step_div  in  DIV_W  clock cycles per step minus 1
- trig_mask  in  OUT_W  trigger compare mask
- trig_value  in  OUT_W  trigger compare value
- start  in  1  start a run (pulse)
- abort  in  1  abandon the current run (pulse)
- rd_en  in  1  pop one capture entry
- dut_ui  out  IN_W  drives DUT ui_in
- dut_uo  in  OUT_W  from DUT uo_out
- dut_rst_n  out  1  DUT active-low reset
- busy  out  1  high in RESET_DUT, ARM and CAPTURE
- done  out  1  high in DONE
- triggered  out  1  trigger has fired this run
- rd_data  out  OUT_W  popped capture word
- rd_valid  out  1  rd_data valid (1-cycle pulse)
- cap_count  out  $clog2(DEPTH)+1  entries still unread

## Operation
- States: IDLE, RESET_DUT, ARM, CAPTURE, DONE.
- Values after reset:
  - State is IDLE.
  - dut_rst_n = 0 and dut_ui = 0.
  - busy, done, triggered, rd_valid, rd_data and cap_count are all 0.
- Pattern writes:
  - Accepted only in IDLE or DONE.
  - Ignored while busy.
- start, accepted in IDLE or DONE:
  - Clears the capture buffer, cap_count, triggered and the read pointer.
  - Latches pat_len, step_div, trig_mask and trig_value.
  - Moves to RESET_DUT.
- RESET_DUT:
  - dut_rst_n = 0 and dut_ui = pattern[0].
  - Lasts exactly RST_CYCLES cycles, then moves to ARM.
- ARM and CAPTURE:
  - dut_rst_n = 1.
  - A step occurs every step_div+1 cycles.
  - At each step, the pattern index advances and wraps from len-1 to 0, and dut_ui updates.
  - dut_uo is registered once (dut_uo_q); compares and captures use dut_uo_q.
- Trigger: (dut_uo_q & mask) == (value & mask) at a step.
  - Sets triggered and moves to CAPTURE.
  - The sample taken at that step is capture entry 0.
  - A mask of 0 fires at the first step.
- CAPTURE:
  - Writes dut_uo_q at each step.
  - After DEPTH entries, moves to DONE and holds dut_rst_n = 0.
- DONE, readout:
  - rd_en pops in capture order, and cap_count decrements.
  - rd_en when cap_count = 0 is ignored; rd_valid stays 0.
  - rd_en outside DONE is ignored.
- abort: from any state goes to IDLE with dut_rst_n = 0; buffer contents become invalid and cap_count = 0.
- Priority: rst > abort > start. start while busy is ignored.

## Timing
- start sampled at edge N: dut_rst_n = 0 for cycles N+1 .. N+RST_CYCLES, and = 1 from N+RST_CYCLES+1.
- First step occurs step_div+1 cycles after entering ARM.
- dut_uo to dut_uo_q: 1 cycle.
- Step to capture-RAM write: same edge as the step.
- rd_en at edge M: rd_data and rd_valid are valid at M+1.
- Back-to-back rd_en is supported at one entry per cycle.
- step_div = 0 steps every cycle.
- Read and write pointers wrap modulo DEPTH.

## Configuration
- IO_HARNESS_TRIGGER_EN
  - Defined: ARM and the trigger compare behave as described above.
  - Undefined: ARM is skipped, and RESET_DUT goes directly to CAPTURE.
  - Undefined: the first step is entry 0, triggered rises with it, and trig_mask/trig_value are unused.

## Structure
- Package io_harness_pkg holds the state enum and the default RST_CYCLES constant.
- One sub-module, io_harness_mem: a DEPTH x W synchronous-write, registered-read RAM.
  - Instantiated twice: pattern memory (W = IN_W) and capture buffer (W = OUT_W).

## Test plan
- Reset, then release: dut_rst_n = 0, dut_ui = 0, cap_count = 0, busy = 0; no activity for 20 cycles.
- Load pattern 0x01, 0x02, 0x03; pat_len = 3; step_div = 0; mask = 0; start.
  - dut_rst_n low for exactly 4 cycles.
  - dut_ui then sequences 01, 02, 03, 01, ...
  - done after 16 steps; cap_count = 16.
- Loop dut_ui back to dut_uo with mask = 0xFF, value = 0x03: the first entry read is 0x03, followed by 01, 02, 03, ...
- step_div = 3: dut_ui changes exactly every 4 cycles.
- Readout: 16 back-to-back rd_en give 16 rd_valid pulses in order; a 17th rd_en gives no rd_valid and cap_count stays 0.
- Control edge cases:
  - abort mid-CAPTURE goes to IDLE next cycle, with dut_rst_n = 0 and cap_count = 0.
  - start together with abort leaves the block in IDLE.
  - pat_we while busy does not change the pattern.
